cam_sccb_capture: RTL and testbench
===================================

Name: cam_sccb_capture

Overview:
- Camera front-end block. After reset it programs the image sensor over SCCB/I2C from an internal register table. It then captures RGB565 pixel byte pairs from the parallel camera bus and presents one pixel per strobe as BGR565 and BGR888.
- It sits between the sensor pins (through the top-level shared SCL/SDA tristate mux) and the frame buffer / JPEG path.
- The block uses a single system clock. All camera bus inputs, including cmos_pclk, are oversampled as data.

Parameters:
- CLK_DIV, 68: clk cycles per SCCB quarter-bit. 27 MHz/68/4 ≈ 100 kHz.
- DEV_ADDR, 8'h78: sensor 8-bit write address.
- WR_GAP, 1024: idle clk cycles between consecutive register writes, and after reset before the first write.

Ports:
- clk  in  1  system clock; everything is synchronous to it.
- rst  in  1  asynchronous, active-high reset.
- cmos_pclk  in  1  sensor pixel clock, sampled as data.
- cmos_vsync  in  1  frame sync, active high.
- cmos_href  in  1  line valid.
- cmos_db  in  8  pixel byte.
- cmos_rst_n  out  1  sensor reset.
- cmos_pwdn  out  1  sensor power-down.
- scl_i  in  1  SCL pin readback (unused, reserved).
- scl_o  out  1  SCL drive value.
- scl_out_en  out  1  SCL drive enable.
- sda_i  in  1  SDA pin readback.
- sda_o  out  1  SDA drive value.
- sda_out_en  out  1  SDA drive enable.
- cam_init_done  out  1  register table fully written.
- nack_err  out  1  sticky flag: some write was NACKed.
- vsync  out  1  registered cmos_vsync, only after init.
- de  out  1  one-cycle pixel-valid strobe.
- half_cmos_clk  out  1  toggles on every captured byte.
- data_bgr565  out  16  {first byte, second byte} of the last pixel.
- data_bgr888  out  24  expanded pixel.

Behaviour:
- Reset values:
  - All outputs 0, except cmos_pwdn=0, cmos_rst_n=0, scl_o=1, sda_o=1.
  - scl_out_en=0, sda_out_en=0.
  - Reset mid-transaction aborts immediately; the table restarts from entry 0.
- Power sequence: one cycle after reset release, cmos_rst_n=1. The block then waits WR_GAP cycles before the first write.
- Register table, 4 entries of {reg16, val8}, written in order:
  - 0x3103=0x11
  - 0x3008=0x82
  - 0x4300=0x6F
  - 0x501F=0x01
  - A WR_GAP wait follows every write.
- Write frame format: START, DEV_ADDR, ACK, reg[15:8], ACK, reg[7:0], ACK, val, ACK, STOP. Bytes are sent MSB first.
- Bit timing: 4 quarters of CLK_DIV cycles each.
  - Q0: SCL=0, SDA is set.
  - Q1 and Q2: SCL=1.
  - Q3: SCL=0.
- START sequence: SDA=1 and SCL=1 for one quarter, then SDA=0 with SCL=1 for one quarter, then SCL=0.
- STOP sequence: SDA=0 then SCL=1 for one quarter, then SDA=1 for one quarter.
- Drive enables during SCCB activity:
  - scl_out_en=1 throughout.
  - sda_out_en=1 except during ACK bit slots.
- ACK handling: sda_i is sampled at the first cycle of ACK Q2. A high sample is a NACK.
  - On NACK: finish with STOP, set nack_err, and retry the same entry after WR_GAP.
  - After 4 consecutive NACKs on one entry, skip to the next entry.
- Completion: after the last entry's gap, cam_init_done=1 (sticky until rst), and scl_out_en/sda_out_en go to 0.
- Input sampling: cmos_* inputs pass through a 2-flop synchronizer, all in the same pipeline. A pclk rising edge is stage2=1 with stage3=0. The byte and href from that same stage are used. Requirement: clk ≥ 3× pclk.
- Capture arming:
  - Capture is off until cam_init_done.
  - It is armed at the first synchronized vsync rising edge after init.
  - While not armed, de=0 and vsync=0. Once armed, vsync follows the synchronized vsync.
- Byte pairing:
  - On a pclk edge with href=1 (armed), the byte toggles phase. Phase 0 latches hi; phase 1 latches lo.
  - The phase is cleared whenever href=0 on a pclk edge, and on the vsync edge.
  - half_cmos_clk toggles on every captured byte.
- Pixel output: one cycle after the edge that captured lo:
  - data_bgr565={hi,lo}; call this P.
  - de=1 for exactly 1 cycle.
  - data_bgr888 = {P[4:0],P[4:2], P[10:5],P[10:9], P[15:11],P[15:13]}.
  - data_* hold between strobes.
- An odd trailing byte at the end of a line is discarded.

Test Plan:
- Reset release: cmos_rst_n rises at cycle 1. The first START occurs after WR_GAP. The first SDA byte decodes 0x78, then 0x31, 0x03, 0x11.
- Sensor model ACKs all writes → exactly 4 transactions are seen (0x3103/0x11, 0x3008/0x82, 0x4300/0x6F, 0x501F/0x01). Then cam_init_done=1, both out_en=0, nack_err=0.
- Model NACKs the first attempt at 0x3008 → nack_err=1, the entry is resent once, and the table completes. Model NACKs 0x4300 4 times → it is skipped.
- Pixel capture, after init, with vsync pulse then href and bytes 0xF8,0x00:
  - data_bgr565=0xF800, data_bgr888=0x0000FF.
  - Bytes 0x07,0xE0 → 0x07E0 / 0x00FF00.
  - Bytes 0x00,0x1F → 0x001F / 0xFF0000.
  - One de pulse per pixel.
- Bytes streamed before the first vsync after init → no de, vsync=0. Odd byte count on a line → last byte dropped; the next line starts at phase 0.
- rst asserted mid-write → SCL/SDA released at once, cam_init_done=0, and the sequence restarts from 0x3103.

Source files
------------

// File: rtl/cam_sccb_capture.sv
// Camera front end: writes the sensor register table over SCCB, then pairs
// RGB565 bytes from the oversampled parallel bus into BGR565/BGR888 pixels.
// Ports:
//   clk, rst            system clock and async active-high reset
//   cmos_*              sensor bus in (sampled as data); cmos_rst_n/pwdn out
//   scl_*, sda_*        SCCB pin drive values, enables and readback
//   cam_init_done       register table written; nack_err sticky NACK flag
//   vsync, de, half_cmos_clk, data_bgr565, data_bgr888  pixel outputs
module cam_sccb_capture #(
  parameter int         CLK_DIV  = 68,
  parameter logic [7:0] DEV_ADDR = 8'h78,
  parameter int         WR_GAP   = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmos_pclk,
  input  logic        cmos_vsync,
  input  logic        cmos_href,
  input  logic [7:0]  cmos_db,
  output logic        cmos_rst_n,
  output logic        cmos_pwdn,
  input  logic        scl_i,
  output logic        scl_o,
  output logic        scl_out_en,
  input  logic        sda_i,
  output logic        sda_o,
  output logic        sda_out_en,
  output logic        cam_init_done,
  output logic        nack_err,
  output logic        vsync,
  output logic        de,
  output logic        half_cmos_clk,
  output logic [15:0] data_bgr565,
  output logic [23:0] data_bgr888
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int GW = (WR_GAP > 1) ? $clog2(WR_GAP) : 1;

  typedef enum logic [2:0] {
    S_GAP, S_START, S_BITS, S_STOP, S_DONE
  } state_t;

  state_t       state_q, state_d;
  logic [DW-1:0] div_q, div_d;
  logic [1:0]   qtr_q, qtr_d;
  logic [3:0]   bit_q, bit_d;
  logic [1:0]   byte_q, byte_d;
  logic [2:0]   ent_q, ent_d;
  logic [1:0]   try_q, try_d;
  logic [GW-1:0] gap_q, gap_d;
  logic         nack_q, nack_d;
  logic         nerr_q, nerr_d;
  logic         done_q, done_d;
  logic         en_q, en_d;
  logic         rstn_q;

  logic         tick;
  logic [23:0]  entry;
  logic [7:0]   cur_byte;
  logic [2:0]   bit_sel;
  logic         ack_slot;

  logic unused_scl;
  assign unused_scl = scl_i;

  function automatic logic [23:0] tbl(input logic [2:0] i);
    case (i)
      3'd0:    tbl = 24'h3103_11;
      3'd1:    tbl = 24'h3008_82;
      3'd2:    tbl = 24'h4300_6F;
      3'd3:    tbl = 24'h501F_01;
      default: tbl = 24'h0;
    endcase
  endfunction

  assign entry = tbl(ent_q);
  assign tick  = (div_q == DW'(CLK_DIV - 1));

  always_comb begin
    case (byte_q)
      2'd0:    cur_byte = DEV_ADDR;
      2'd1:    cur_byte = entry[23:16];
      2'd2:    cur_byte = entry[15:8];
      default: cur_byte = entry[7:0];
    endcase
  end

  assign bit_sel = 3'(4'd7 - bit_q);

  // SCCB sequencer: next state
  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    qtr_d   = qtr_q;
    bit_d   = bit_q;
    byte_d  = byte_q;
    ent_d   = ent_q;
    try_d   = try_q;
    gap_d   = gap_q;
    nack_d  = nack_q;
    nerr_d  = nerr_q;
    done_d  = done_q;
    en_d    = en_q;
    if (state_q == S_START || state_q == S_BITS ||
        state_q == S_STOP) begin
      div_d = tick ? '0 : div_q + 1'b1;
    end
    case (state_q)
      S_GAP: begin
        div_d = '0;
        gap_d = gap_q + 1'b1;
        if (gap_q == GW'(WR_GAP - 1)) begin
          gap_d = '0;
          qtr_d = 2'd0;
          if (ent_q == 3'd4) begin
            state_d = S_DONE;
            en_d    = 1'b0;
            done_d  = 1'b1;
          end else begin
            state_d = S_START;
            en_d    = 1'b1;
          end
        end
      end
      S_START: begin
        if (tick) begin
          qtr_d = qtr_q + 1'b1;
          if (qtr_q == 2'd1) begin
            state_d = S_BITS;
            qtr_d   = 2'd0;
            bit_d   = 4'd0;
            byte_d  = 2'd0;
            nack_d  = 1'b0;
          end
        end
      end
      S_BITS: begin
        // ACK is sampled once, on the first cycle of Q2
        if (ack_slot && qtr_q == 2'd2 && div_q == '0 && sda_i)
          nack_d = 1'b1;
        if (tick) begin
          qtr_d = qtr_q + 1'b1;
          if (qtr_q == 2'd3) begin
            if (bit_q == 4'd8) begin
              bit_d = 4'd0;
              if (byte_q == 2'd3 || nack_q) begin
                state_d = S_STOP;
                qtr_d   = 2'd0;
              end else begin
                byte_d = byte_q + 1'b1;
              end
            end else begin
              bit_d = bit_q + 1'b1;
            end
          end
        end
      end
      S_STOP: begin
        if (tick) begin
          qtr_d = qtr_q + 1'b1;
          if (qtr_q == 2'd2) begin
            state_d = S_GAP;
            qtr_d   = 2'd0;
            if (nack_q) begin
              nerr_d = 1'b1;
              if (try_q == 2'd3) begin
                ent_d = ent_q + 1'b1;
                try_d = 2'd0;
              end else begin
                try_d = try_q + 1'b1;
              end
            end else begin
              ent_d = ent_q + 1'b1;
              try_d = 2'd0;
            end
          end
        end
      end
      default: ;
    endcase
  end

  // Pin values are pure decodes of the sequencer state
  always_comb begin
    scl_o    = 1'b1;
    sda_o    = 1'b1;
    ack_slot = (state_q == S_BITS) && (bit_q == 4'd8);
    case (state_q)
      S_START: sda_o = (qtr_q == 2'd0);
      S_BITS: begin
        scl_o = (qtr_q == 2'd1) || (qtr_q == 2'd2);
        sda_o = ack_slot ? 1'b1 : cur_byte[bit_sel];
      end
      S_STOP: begin
        scl_o = (qtr_q != 2'd0);
        sda_o = (qtr_q == 2'd2);
      end
      default: ;
    endcase
  end

  assign scl_out_en    = en_q;
  assign sda_out_en    = en_q && !ack_slot;
  assign cam_init_done = done_q;
  assign nack_err      = nerr_q;
  assign cmos_rst_n    = rstn_q;
  assign cmos_pwdn     = 1'b0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_GAP;
      div_q   <= '0;
      qtr_q   <= 2'd0;
      bit_q   <= 4'd0;
      byte_q  <= 2'd0;
      ent_q   <= 3'd0;
      try_q   <= 2'd0;
      gap_q   <= '0;
      nack_q  <= 1'b0;
      nerr_q  <= 1'b0;
      done_q  <= 1'b0;
      en_q    <= 1'b0;
      rstn_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      qtr_q   <= qtr_d;
      bit_q   <= bit_d;
      byte_q  <= byte_d;
      ent_q   <= ent_d;
      try_q   <= try_d;
      gap_q   <= gap_d;
      nack_q  <= nack_d;
      nerr_q  <= nerr_d;
      done_q  <= done_d;
      en_q    <= en_d;
      rstn_q  <= 1'b1;
    end
  end

  // Capture path: {pclk, vsync, href, db} through one shared pipeline
  logic [10:0] s1_q, s2_q;
  logic        p3_q, v3_q;
  logic        armed_q, armed_d;
  logic        phase_q, phase_d;
  logic [7:0]  hi_q, hi_d;
  logic        half_q, half_d;
  logic        de_q, de_d;
  logic        vs_q, vs_d;
  logic [15:0] d565_q, d565_d;
  logic [23:0] d888_q, d888_d;
  logic        pclk_rise, vs_rise;

  function automatic logic [23:0] expand(input logic [15:0] p);
    expand = {p[4:0], p[4:2], p[10:5], p[10:9],
              p[15:11], p[15:13]};
  endfunction

  assign pclk_rise = s2_q[10] && !p3_q;
  assign vs_rise   = s2_q[9] && !v3_q;

  always_comb begin
    armed_d = armed_q | (done_q & vs_rise);
    phase_d = phase_q;
    hi_d    = hi_q;
    half_d  = half_q;
    de_d    = 1'b0;
    d565_d  = d565_q;
    d888_d  = d888_q;
    vs_d    = armed_d ? s2_q[9] : 1'b0;
    if (armed_q) begin
      if (vs_rise) begin
        phase_d = 1'b0;
      end else if (pclk_rise) begin
        if (s2_q[8]) begin
          half_d  = ~half_q;
          phase_d = ~phase_q;
          if (!phase_q) begin
            hi_d = s2_q[7:0];
          end else begin
            de_d   = 1'b1;
            d565_d = {hi_q, s2_q[7:0]};
            d888_d = expand({hi_q, s2_q[7:0]});
          end
        end else begin
          // href low drops any odd trailing byte
          phase_d = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q    <= '0;
      s2_q    <= '0;
      p3_q    <= 1'b0;
      v3_q    <= 1'b0;
      armed_q <= 1'b0;
      phase_q <= 1'b0;
      hi_q    <= 8'h0;
      half_q  <= 1'b0;
      de_q    <= 1'b0;
      vs_q    <= 1'b0;
      d565_q  <= 16'h0;
      d888_q  <= 24'h0;
    end else begin
      s1_q    <= {cmos_pclk, cmos_vsync, cmos_href, cmos_db};
      s2_q    <= s1_q;
      p3_q    <= s2_q[10];
      v3_q    <= s2_q[9];
      armed_q <= armed_d;
      phase_q <= phase_d;
      hi_q    <= hi_d;
      half_q  <= half_d;
      de_q    <= de_d;
      vs_q    <= vs_d;
      d565_q  <= d565_d;
      d888_q  <= d888_d;
    end
  end

  assign vsync         = vs_q;
  assign de            = de_q;
  assign half_cmos_clk = half_q;
  assign data_bgr565   = d565_q;
  assign data_bgr888   = d888_q;

endmodule

// File: tb/tb_cam_sccb_capture.sv
// Bench for cam_sccb_capture: SCCB sensor model plus pixel scoreboard.
// Expected transactions and pixels are queued by stimulus, popped by monitors.
module tb_cam_sccb_capture;

  localparam int CD = 4;
  localparam int WG = 40;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmos_pclk = 1'b0;
  logic        cmos_vsync = 1'b0;
  logic        cmos_href = 1'b0;
  logic [7:0]  cmos_db = 8'h0;
  logic        cmos_rst_n, cmos_pwdn;
  logic        scl_i, scl_o, scl_out_en;
  logic        sda_i = 1'b1;
  logic        sda_o, sda_out_en;
  logic        cam_init_done, nack_err;
  logic        vsync, de, half_cmos_clk;
  logic [15:0] data_bgr565;
  logic [23:0] data_bgr888;

  always #5 clk = ~clk;

  cam_sccb_capture #(
    .CLK_DIV (CD),
    .DEV_ADDR(8'h78),
    .WR_GAP  (WG)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .cmos_pclk    (cmos_pclk),
    .cmos_vsync   (cmos_vsync),
    .cmos_href    (cmos_href),
    .cmos_db      (cmos_db),
    .cmos_rst_n   (cmos_rst_n),
    .cmos_pwdn    (cmos_pwdn),
    .scl_i        (scl_i),
    .scl_o        (scl_o),
    .scl_out_en   (scl_out_en),
    .sda_i        (sda_i),
    .sda_o        (sda_o),
    .sda_out_en   (sda_out_en),
    .cam_init_done(cam_init_done),
    .nack_err     (nack_err),
    .vsync        (vsync),
    .de           (de),
    .half_cmos_clk(half_cmos_clk),
    .data_bgr565  (data_bgr565),
    .data_bgr888  (data_bgr888)
  );

  wire scl_l = scl_out_en ? scl_o : 1'b1;
  wire sda_l = sda_out_en ? sda_o : sda_i;
  assign scl_i = scl_l;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // {addr, reg, val, acked}
  typedef logic [32:0] tx_t;
  tx_t         exp_tx[$];
  logic [39:0] exp_px[$];

  // SCCB sensor model
  logic       pscl = 1'b1, psda = 1'b1;
  logic       in_fr = 1'b0, rose = 1'b0, ackv = 1'b0;
  int         bitc = 0, bytec = 0, cyc = 0, first_start = -1;
  int         n3008 = 0, n4300 = 0;
  logic [7:0] sh = 8'h0;
  logic [7:0] by[4];
  tx_t        obs, ex;

  always @(negedge clk) begin
    if (rst) begin
      in_fr = 1'b0; rose = 1'b0; ackv = 1'b0;
      bitc = 0; bytec = 0; cyc = 0;
      pscl = 1'b1; psda = 1'b1; sda_i = 1'b1;
    end else begin
      cyc++;
      if (pscl && scl_l && psda && !sda_l) begin
        in_fr = 1'b1; bitc = 0; bytec = 0; rose = 1'b0;
        if (first_start < 0) first_start = cyc;
      end else if (pscl && scl_l && !psda && sda_l) begin
        if (in_fr && bytec == 4) begin
          obs = {by[0], by[1], by[2], by[3], ~ackv};
          ex  = (exp_tx.size() > 0) ? exp_tx.pop_front() : '0;
          chk("sccb_tx", obs, ex);
        end
        in_fr = 1'b0;
      end else if (in_fr && !pscl && scl_l) begin
        rose = 1'b1;
        if (bitc < 8) sh = {sh[6:0], sda_l};
      end else if (in_fr && pscl && !scl_l && rose) begin
        rose = 1'b0;
        if (bitc < 8) begin
          bitc++;
          if (bitc == 8 && bytec < 4) begin
            by[bytec] = sh;
            ackv = 1'b0;
            if (bytec == 3) begin
              if ({by[1], by[2]} == 16'h3008 && n3008 > 0) begin
                ackv = 1'b1; n3008--;
              end else if ({by[1], by[2]} == 16'h4300 && n4300 > 0) begin
                ackv = 1'b1; n4300--;
              end
            end
          end
        end else begin
          bitc = 0;
          bytec++;
        end
      end
      pscl  = scl_l;
      psda  = sda_l;
      sda_i = (in_fr && bitc == 8) ? ackv : 1'b1;
    end
  end

  // pixel monitor
  logic        prev_de = 1'b0, prev_half = 1'b0;
  int          toggles = 0;
  logic [39:0] px;

  always @(negedge clk) begin
    if (!rst) begin
      if (de) begin
        chk("de_one_cycle", prev_de, 1'b0);
        if (exp_px.size() == 0) begin
          chk("px_unexpected_de", de, 1'b0);
        end else begin
          px = exp_px.pop_front();
          chk("pixel", {data_bgr565, data_bgr888}, px);
        end
      end
      if (half_cmos_clk != prev_half) toggles++;
    end
    prev_de   = de;
    prev_half = half_cmos_clk;
  end

  task automatic send_line(input logic [7:0] b0, b1, b2, input int n);
    logic [7:0] b[3];
    b = '{b0, b1, b2};
    cmos_href = 1'b1;
    for (int i = 0; i < n; i++) begin
      cmos_db = b[i];
      cmos_pclk = 1'b0; step(3);
      cmos_pclk = 1'b1; step(3);
    end
    cmos_href = 1'b0;
    repeat (2) begin
      cmos_pclk = 1'b0; step(3);
      cmos_pclk = 1'b1; step(3);
    end
    cmos_pclk = 1'b0; step(3);
  endtask

  task automatic vs_pulse(output logic seen);
    cmos_vsync = 1'b1; step(6);
    seen = vsync;      step(6);
    cmos_vsync = 1'b0; step(6);
  endtask

  task automatic wait_done(input string nm);
    for (int i = 0; i < 20000 && !cam_init_done; i++) step(1);
    chk(nm, cam_init_done, 1'b1);
  endtask

  logic v;

  initial begin
    step(3);
    chk("reset_ctrl", {cmos_rst_n, cmos_pwdn, scl_o, sda_o, scl_out_en,
        sda_out_en, cam_init_done, nack_err}, 8'b0011_0000);
    chk("reset_px", {de, vsync, half_cmos_clk, data_bgr565,
        data_bgr888}, '0);
    exp_tx.push_back({8'h78, 16'h3103, 8'h11, 1'b1});
    exp_tx.push_back({8'h78, 16'h3008, 8'h82, 1'b1});
    exp_tx.push_back({8'h78, 16'h4300, 8'h6F, 1'b1});
    exp_tx.push_back({8'h78, 16'h501F, 8'h01, 1'b1});
    rst = 1'b0;
    #1;
    chk("rst_n_low_at_release", cmos_rst_n, 1'b0);
    step(1);
    chk("rst_n_after_1", cmos_rst_n, 1'b1);

    // no capture or vsync before init completes
    vs_pulse(v);
    chk("vsync_before_init", v, 1'b0);
    send_line(8'hF8, 8'h00, 8'h00, 2);

    wait_done("init_done_a");
    chk("first_start_win",
        (first_start >= WG) && (first_start <= WG + 2 * CD), 1'b1);
    chk("done_state_a", {cam_init_done, scl_out_en, sda_out_en,
        nack_err}, 4'b1000);
    chk("tx_all_seen_a", exp_tx.size(), 0);

    // bytes after init but before the arming vsync
    send_line(8'h07, 8'hE0, 8'h00, 2);
    vs_pulse(v);
    chk("vsync_armed", v, 1'b1);

    exp_px.push_back({16'hF800, 24'h0000FF});
    send_line(8'hF8, 8'h00, 8'h00, 2);
    exp_px.push_back({16'h07E0, 24'h00FF00});
    send_line(8'h07, 8'hE0, 8'h00, 2);
    exp_px.push_back({16'h001F, 24'hFF0000});
    send_line(8'h00, 8'h1F, 8'h00, 2);
    exp_px.push_back({16'h1234, 24'hA54510});
    send_line(8'h12, 8'h34, 8'h56, 3);
    exp_px.push_back({16'hABCD, 24'h6B79AD});
    send_line(8'hAB, 8'hCD, 8'h00, 2);
    step(10);
    chk("px_all_seen", exp_px.size(), 0);
    chk("half_toggles", toggles, 11);

    // reset clears done; then abort a write mid-frame
    rst = 1'b1;
    #1;
    chk("rst_clears_done", {cam_init_done, nack_err}, 2'b00);
    step(3);
    rst = 1'b0;
    for (int i = 0; i < 2000 && !(in_fr && bytec >= 1); i++) step(1);
    chk("mid_frame_reached", in_fr && bytec >= 1, 1'b1);
    rst = 1'b1;
    #1;
    chk("abort_release", {scl_out_en, sda_out_en, scl_o, sda_o,
        cam_init_done}, 5'b00110);
    step(3);
    n3008 = 1;
    n4300 = 4;
    exp_tx.push_back({8'h78, 16'h3103, 8'h11, 1'b1});
    exp_tx.push_back({8'h78, 16'h3008, 8'h82, 1'b0});
    exp_tx.push_back({8'h78, 16'h3008, 8'h82, 1'b1});
    repeat (4) exp_tx.push_back({8'h78, 16'h4300, 8'h6F, 1'b0});
    exp_tx.push_back({8'h78, 16'h501F, 8'h01, 1'b1});
    rst = 1'b0;
    wait_done("init_done_b");
    chk("done_state_b", {cam_init_done, scl_out_en, sda_out_en,
        nack_err}, 4'b1001);
    chk("tx_all_seen_b", exp_tx.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
